qnigma_mdio_ctrl: RTL and testbench

Management sequencer placed directly above the MDIO serial engine. Runs a PHY soft-reset/initialisation sequence after reset, then arbitrates the single engine between a host register-access port and an internal periodic link-status poller. Publishes link state and completion data; the engine's `send`, `r_nw`, address and write-data inputs are driven only by this block.

---
 rtl/qnigma_mdio_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_qnigma_mdio_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qnigma_mdio_ctrl.sv
// MDIO management sequencer: PHY reset/init sequence, then arbitration of the serial engine
// between host register accesses and a periodic BMSR link poller.
module qnigma_mdio_ctrl #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int unsigned POLL_PERIOD  = 1_000_000,
  parameter int unsigned INIT_RETRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_req,
  input  logic        host_r_nw,
  input  logic [4:0]  host_regad,
  input  logic [15:0] host_wdat,
  output logic        host_ack,
  output logic        host_done,
  output logic [15:0] host_rdat,
  input  logic        poll_en,
  output logic        link_up,
  output logic        link_chg,
  output logic        init_done,
  output logic        init_err,
  output logic        eng_send,
  output logic        eng_r_nw,
  output logic [4:0]  eng_phyad,
  output logic [4:0]  eng_regad,
  output logic [15:0] eng_dat_in,
  input  logic        eng_ready,
  input  logic        eng_done,
  input  logic [15:0] eng_dat_out
);

  localparam int unsigned TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned RW = $clog2(INIT_RETRIES + 1);

  typedef enum logic [2:0] {StInitWr, StInitRd, StIdle, StIssue, StWait} state_e;
  typedef enum logic {OwnHost, OwnPoll} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d, last_q, last_d;
  logic          arm_q, arm_d, sent_q, sent_d;
  logic [RW-1:0] retry_q, retry_d, retry_inc;
  logic [TW-1:0] timer_q, timer_d;
  logic          poll_pend_q, poll_pend_d, wrap, poll_grant, host_ok;
  logic          r_nw_q, r_nw_d;
  logic [4:0]    regad_q, regad_d;
  logic [15:0]   dat_q, dat_d, rdat_q, rdat_d;
  logic          link_up_q, link_up_d, link_chg_q, link_chg_d, host_done_q, host_done_d;
  logic          init_done_q, init_done_d, init_err_q, init_err_d;

  // Timer keeps running across transactions; a wrap while a poll is already pending is lost.
  always_comb begin
    timer_d = timer_q;
    wrap    = 1'b0;
    if (!poll_en) begin
      timer_d = '0;
    end else if (init_done_q) begin
      if (timer_q == TW'(POLL_PERIOD - 1)) begin
        timer_d = '0;
        wrap    = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
    poll_pend_d = poll_grant ? 1'b0 : (poll_pend_q | wrap);
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    arm_d       = arm_q;
    sent_d      = sent_q;
    retry_d     = retry_q;
    retry_inc   = retry_q + RW'(1);
    r_nw_d      = r_nw_q;
    regad_d     = regad_q;
    dat_d       = dat_q;
    rdat_d      = rdat_q;
    link_up_d   = link_up_q;
    link_chg_d  = 1'b0;
    host_done_d = 1'b0;
    init_done_d = init_done_q;
    init_err_d  = init_err_q;
    host_ack    = 1'b0;
    eng_send    = 1'b0;
    poll_grant  = 1'b0;
    // Blocks a host grant in the host_done cycle so ack and done never coincide.
    host_ok     = host_req && !host_done_q;
    unique case (state_q)
      StInitWr: begin
        if (!arm_q) begin
          arm_d   = 1'b1;
          r_nw_d  = 1'b0;
          regad_d = 5'd0;
          dat_d   = 16'h8000;
        end else if (!sent_q) begin
          eng_send = eng_ready;
          sent_d   = eng_ready;
        end else if (eng_done) begin
          state_d = StInitRd;
          sent_d  = 1'b0;
          r_nw_d  = 1'b1;
          dat_d   = 16'h0000;
        end
      end
      StInitRd: begin
        if (!sent_q) begin
          eng_send = eng_ready;
          sent_d   = eng_ready;
        end else if (eng_done) begin
          sent_d = 1'b0;
          if (!eng_dat_out[15]) begin
            init_done_d = 1'b1;
            arm_d       = 1'b0;
            state_d     = StIdle;
          end else begin
            retry_d = retry_inc;
            if (retry_inc == RW'(INIT_RETRIES)) begin
              init_err_d  = 1'b1;
              init_done_d = 1'b1;
              arm_d       = 1'b0;
              state_d     = StIdle;
            end
          end
        end
      end
      StIdle: begin
        if (host_ok && (!poll_pend_q || last_q == OwnPoll)) begin
          host_ack = 1'b1;
          owner_d  = OwnHost;
          last_d   = OwnHost;
          r_nw_d   = host_r_nw;
          regad_d  = host_regad;
          dat_d    = host_wdat;
          state_d  = StIssue;
        end else if (poll_pend_q) begin
          poll_grant = 1'b1;
          owner_d    = OwnPoll;
          last_d     = OwnPoll;
          r_nw_d     = 1'b1;
          regad_d    = 5'd1;
          dat_d      = 16'h0000;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        eng_send = eng_ready;
        if (eng_ready) state_d = StWait;
      end
      StWait: begin
        if (eng_done) begin
          state_d = StIdle;
          if (owner_q == OwnHost) begin
            host_done_d = 1'b1;
            if (r_nw_q) rdat_d = eng_dat_out;
          end else begin
            link_up_d  = eng_dat_out[2];
            link_chg_d = eng_dat_out[2] != link_up_q;
          end
        end
      end
      default: state_d = StInitWr;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StInitWr;
      owner_q     <= OwnHost;
      last_q      <= OwnHost;
      arm_q       <= 1'b0;
      sent_q      <= 1'b0;
      retry_q     <= '0;
      timer_q     <= '0;
      poll_pend_q <= 1'b0;
      r_nw_q      <= 1'b0;
      regad_q     <= '0;
      dat_q       <= '0;
      rdat_q      <= '0;
      link_up_q   <= 1'b0;
      link_chg_q  <= 1'b0;
      host_done_q <= 1'b0;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      arm_q       <= arm_d;
      sent_q      <= sent_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      poll_pend_q <= poll_pend_d;
      r_nw_q      <= r_nw_d;
      regad_q     <= regad_d;
      dat_q       <= dat_d;
      rdat_q      <= rdat_d;
      link_up_q   <= link_up_d;
      link_chg_q  <= link_chg_d;
      host_done_q <= host_done_d;
      init_done_q <= init_done_d;
      init_err_q  <= init_err_d;
    end
  end

  assign host_done  = host_done_q;
  assign host_rdat  = rdat_q;
  assign link_up    = link_up_q;
  assign link_chg   = link_chg_q;
  assign init_done  = init_done_q;
  assign init_err   = init_err_q;
  assign eng_r_nw   = r_nw_q;
  assign eng_phyad  = PHY_ADDR;
  assign eng_regad  = regad_q;
  assign eng_dat_in = dat_q;

endmodule

// File: tb/tb_qnigma_mdio_ctrl.sv
// Scoreboard bench for qnigma_mdio_ctrl: a behavioural MDIO engine plus monitors that pop
// expected engine transactions, host completions and link changes.
module tb_qnigma_mdio_ctrl;

  logic        clk, rst;
  logic        host_req, host_r_nw, host_ack, host_done;
  logic [4:0]  host_regad;
  logic [15:0] host_wdat, host_rdat;
  logic        poll_en, link_up, link_chg, init_done, init_err;
  logic        eng_send, eng_r_nw, eng_ready, eng_done;
  logic [4:0]  eng_phyad, eng_regad;
  logic [15:0] eng_dat_in, eng_dat_out;

  qnigma_mdio_ctrl #(
    .PHY_ADDR    (5'd1),
    .POLL_PERIOD (100),
    .INIT_RETRIES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .host_req   (host_req),
    .host_r_nw  (host_r_nw),
    .host_regad (host_regad),
    .host_wdat  (host_wdat),
    .host_ack   (host_ack),
    .host_done  (host_done),
    .host_rdat  (host_rdat),
    .poll_en    (poll_en),
    .link_up    (link_up),
    .link_chg   (link_chg),
    .init_done  (init_done),
    .init_err   (init_err),
    .eng_send   (eng_send),
    .eng_r_nw   (eng_r_nw),
    .eng_phyad  (eng_phyad),
    .eng_regad  (eng_regad),
    .eng_dat_in (eng_dat_in),
    .eng_ready  (eng_ready),
    .eng_done   (eng_done),
    .eng_dat_out(eng_dat_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        r_nw;
    logic [4:0]  regad;
    logic [15:0] dat;
  } txn_t;

  txn_t        exp_txn[$];
  logic [15:0] resp_q[$];
  logic [15:0] exp_rdat[$];
  logic        exp_link[$];
  int          checks = 0, failures = 0;
  int          n_send = 0, n_ack = 0, n_chg = 0, n_hdone = 0;
  int          lat = 3;
  logic [15:0] model_rdat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic rnw, input logic [4:0] ra, input logic [15:0] d);
    txn_t t;
    t.r_nw  = rnw;
    t.regad = ra;
    t.dat   = d;
    return t;
  endfunction

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_host_ack", 32'(host_ack), 0);
    chk("rst_host_done", 32'(host_done), 0);
    chk("rst_host_rdat", 32'(host_rdat), 0);
    chk("rst_link_up", 32'(link_up), 0);
    chk("rst_link_chg", 32'(link_chg), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_init_err", 32'(init_err), 0);
    chk("rst_eng_send", 32'(eng_send), 0);
    chk("rst_eng_r_nw", 32'(eng_r_nw), 0);
    chk("rst_eng_regad", 32'(eng_regad), 0);
    chk("rst_eng_dat_in", 32'(eng_dat_in), 0);
    chk("rst_eng_phyad", 32'(eng_phyad), 1);
  endtask

  // Monitor: pops expectations whenever the DUT presents a send, completion or link change.
  initial begin
    txn_t        t;
    logic [15:0] e;
    logic        el;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (host_ack) n_ack++;
        if (host_done) begin
          n_hdone++;
          chk("ack_with_done", 32'(host_ack), 0);
          if (exp_rdat.size() == 0) chk("host_done_unexpected", 32'(host_done), 0);
          else begin
            e = exp_rdat.pop_front();
            chk("host_rdat", 32'(host_rdat), 32'(e));
          end
        end
        if (link_chg) begin
          n_chg++;
          if (exp_link.size() == 0) chk("link_chg_unexpected", 32'(link_chg), 0);
          else begin
            el = exp_link.pop_front();
            chk("link_up", 32'(link_up), 32'(el));
          end
        end
        if (eng_send) begin
          n_send++;
          chk("eng_phyad", 32'(eng_phyad), 1);
          if (exp_txn.size() == 0) chk("send_unexpected", 32'(eng_send), 0);
          else begin
            t = exp_txn.pop_front();
            chk("eng_r_nw", 32'(eng_r_nw), 32'(t.r_nw));
            chk("eng_regad", 32'(eng_regad), 32'(t.regad));
            if (!t.r_nw) chk("eng_dat_in", 32'(eng_dat_in), 32'(t.dat));
          end
        end
      end
    end
  end

  // Behavioural engine: busy for 'lat' cycles after a send, then a one-cycle done pulse.
  initial begin
    logic        s_send, s_rnw;
    int          cnt;
    logic [15:0] pend;
    eng_ready   = 1'b1;
    eng_done    = 1'b0;
    eng_dat_out = 16'h0;
    cnt         = 0;
    pend        = 16'h0;
    forever begin
      @(negedge clk);
      s_send = eng_send;
      s_rnw  = eng_r_nw;
      @(posedge clk);
      #1;
      if (!rst) begin
        cnt       = 0;
        eng_ready = 1'b1;
        eng_done  = 1'b0;
      end else if (eng_done) begin
        eng_done = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          eng_done    = 1'b1;
          eng_ready   = 1'b1;
          eng_dat_out = pend;
        end
      end else if (s_send) begin
        eng_ready = 1'b0;
        cnt       = lat;
        pend      = 16'h0;
        if (s_rnw && resp_q.size() > 0) pend = resp_q.pop_front();
      end
    end
  end

  task automatic host_txn(input logic rnw, input logic [4:0] ra, input logic [15:0] wd,
                          input logic [15:0] rd);
    int a0, d0;
    exp_txn.push_back(mk(rnw, ra, wd));
    if (rnw) begin
      resp_q.push_back(rd);
      model_rdat = rd;
    end
    exp_rdat.push_back(model_rdat);
    a0 = n_ack;
    d0 = n_hdone;
    @(posedge clk);
    #1;
    host_req   = 1'b1;
    host_r_nw  = rnw;
    host_regad = ra;
    host_wdat  = wd;
    for (int i = 0; i < 50 && n_ack == a0; i++) nclk();
    // Scramble the host fields mid-transaction; the DUT must have latched them.
    @(posedge clk);
    #1;
    host_req   = 1'b0;
    host_r_nw  = ~rnw;
    host_regad = ~ra;
    host_wdat  = ~wd;
    for (int i = 0; i < 100 && n_hdone == d0; i++) nclk();
    chk("host_ack_count", 32'(n_ack - a0), 1);
    chk("host_done_count", 32'(n_hdone - d0), 1);
  endtask

  initial begin
    int s0, a0, d0, c0;
    rst        = 1'b1;
    host_req   = 1'b0;
    host_r_nw  = 1'b0;
    host_regad = 5'd0;
    host_wdat  = 16'h0;
    poll_en    = 1'b0;
    model_rdat = 16'h0;
    #3 rst = 1'b0;

    // Init success: BMCR reads 8000, 8000, 0000.
    exp_txn.push_back(mk(1'b0, 5'd0, 16'h8000));
    for (int i = 0; i < 3; i++) exp_txn.push_back(mk(1'b1, 5'd0, 16'h0));
    resp_q.push_back(16'h8000);
    resp_q.push_back(16'h8000);
    resp_q.push_back(16'h0000);
    repeat (2) nclk();
    chk_reset();
    s0 = n_send;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 300 && !init_done; i++) nclk();
    chk("init_done", 32'(init_done), 1);
    chk("init_err", 32'(init_err), 0);
    chk("init_sends", 32'(n_send - s0), 4);
    chk("init_queue_empty", 32'(exp_txn.size()), 0);

    // Host write then host read.
    host_txn(1'b0, 5'd4, 16'h01E1, 16'h0);
    chk("wr_rdat_unchanged", 32'(host_rdat), 0);
    host_txn(1'b1, 5'd2, 16'h0, 16'h0141);
    chk("rd_rdat", 32'(host_rdat), 32'h0141);

    // Poll/link: BMSR 0004, 0004, 0000 -> two link_chg pulses.
    for (int i = 0; i < 3; i++) exp_txn.push_back(mk(1'b1, 5'd1, 16'h0));
    resp_q.push_back(16'h0004);
    resp_q.push_back(16'h0004);
    resp_q.push_back(16'h0000);
    exp_link.push_back(1'b1);
    exp_link.push_back(1'b0);
    s0 = n_send;
    c0 = n_chg;
    @(posedge clk);
    #1 poll_en = 1'b1;
    for (int i = 0; i < 1000 && n_send < s0 + 3; i++) nclk();
    @(posedge clk);
    #1 poll_en = 1'b0;
    repeat (20) nclk();
    chk("poll_sends", 32'(n_send - s0), 3);
    chk("link_chg_count", 32'(n_chg - c0), 2);
    chk("link_up_final", 32'(link_up), 0);

    // Fairness: long engine latency keeps a poll pending at every completion.
    lat = 120;
    for (int i = 0; i < 3; i++) begin
      exp_txn.push_back(mk(1'b1, 5'd3, 16'h0));
      exp_txn.push_back(mk(1'b1, 5'd1, 16'h0));
    end
    resp_q.push_back(16'h1111);
    resp_q.push_back(16'h0000);
    resp_q.push_back(16'h2222);
    resp_q.push_back(16'h0000);
    resp_q.push_back(16'h3333);
    resp_q.push_back(16'h0000);
    exp_rdat.push_back(16'h1111);
    exp_rdat.push_back(16'h2222);
    exp_rdat.push_back(16'h3333);
    s0 = n_send;
    a0 = n_ack;
    d0 = n_hdone;
    c0 = n_chg;
    @(posedge clk);
    #1;
    host_req   = 1'b1;
    host_r_nw  = 1'b1;
    host_regad = 5'd3;
    host_wdat  = 16'h0;
    poll_en    = 1'b1;
    for (int i = 0; i < 1500 && n_send < s0 + 5; i++) nclk();
    @(posedge clk);
    #1;
    host_req = 1'b0;
    poll_en  = 1'b0;
    for (int i = 0; i < 400 && n_send < s0 + 6; i++) nclk();
    repeat (lat + 10) nclk();
    chk("fair_sends", 32'(n_send - s0), 6);
    chk("fair_acks", 32'(n_ack - a0), 3);
    chk("fair_dones", 32'(n_hdone - d0), 3);
    chk("fair_queue_empty", 32'(exp_txn.size()), 0);
    chk("fair_no_link_chg", 32'(n_chg - c0), 0);
    chk("fair_rdat", 32'(host_rdat), 32'h3333);

    // Reset in WAIT of a host read.
    lat = 20;
    exp_txn.push_back(mk(1'b1, 5'd5, 16'h0));
    resp_q.push_back(16'hABCD);
    s0 = n_send;
    @(posedge clk);
    #1;
    host_req   = 1'b1;
    host_r_nw  = 1'b1;
    host_regad = 5'd5;
    for (int i = 0; i < 50 && n_send == s0; i++) nclk();
    @(posedge clk);
    #1 host_req = 1'b0;
    repeat (5) nclk();
    @(posedge clk);
    #1 rst = 1'b0;
    exp_txn.delete();
    resp_q.delete();
    exp_rdat.delete();
    exp_link.delete();
    model_rdat = 16'h0;
    nclk();
    chk_reset();

    // Restart at INIT_WR, BMCR stuck at 8000 -> init timeout after 4 reads.
    lat = 3;
    exp_txn.push_back(mk(1'b0, 5'd0, 16'h8000));
    for (int i = 0; i < 4; i++) begin
      exp_txn.push_back(mk(1'b1, 5'd0, 16'h0));
      resp_q.push_back(16'h8000);
    end
    s0 = n_send;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 400 && !init_done; i++) nclk();
    chk("to_init_done", 32'(init_done), 1);
    chk("to_init_err", 32'(init_err), 1);
    chk("to_sends", 32'(n_send - s0), 5);
    chk("to_queue_empty", 32'(exp_txn.size()), 0);

    // Polling starts after a failed init.
    exp_txn.push_back(mk(1'b1, 5'd1, 16'h0));
    resp_q.push_back(16'h0004);
    exp_link.push_back(1'b1);
    c0 = n_chg;
    @(posedge clk);
    #1 poll_en = 1'b1;
    for (int i = 0; i < 300 && n_chg == c0; i++) nclk();
    chk("to_poll_chg", 32'(n_chg - c0), 1);
    chk("to_link_up", 32'(link_up), 1);
    chk("to_rdat_reset", 32'(host_rdat), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
